// File: rtl/microcode_pkg.sv
// Shared types and helpers for the microcode sequencer: state encoding,
// control-word bit positions and control-store address packing.
package microcode_pkg;

  typedef enum logic [0:0] {
    SEQ_RUN,
    SEQ_HALT
  } seqState_e;

  localparam int unsigned UWORD_EOI_BIT  = 0;
  localparam int unsigned UWORD_NIMM_BIT = 1;

  // Packs {flags, instr, step}; caller truncates to its own address width.
  function automatic logic [63:0] buildUAddr(
    input logic [31:0] flags,
    input logic [31:0] instr,
    input logic [31:0] step,
    input int unsigned instrW,
    input int unsigned stepW
  );
    logic [63:0] addr;
    addr = ({32'b0, flags} << (instrW + stepW)) | ({32'b0, instr} << stepW) | {32'b0, step};
    return addr;
  endfunction

endpackage

// File: rtl/seq_step_counter.sv
// Microstep register: synchronous clear wins over hold; otherwise counts up
// and wraps naturally at 2^STEP_W.
module seq_step_counter #(
  parameter int unsigned STEP_W = 3
) (
  input  logic              i_clk,
  input  logic              i_nReset,
  input  logic              i_clear,
  input  logic              i_hold,
  output logic [STEP_W-1:0] o_step
);

  logic [STEP_W-1:0] r_step;

  always_ff @(posedge i_clk) begin
    if (!i_nReset) begin
      r_step <= '0;
    end else if (i_clear) begin
      r_step <= '0;
    end else if (!i_hold) begin
      r_step <= r_step + STEP_W'(1);
    end
  end

  assign o_step = r_step;

endmodule

// File: rtl/microcode_sequencer.sv
// Microcoded control sequencer: instruction register, microstep counter and
// control-store addressing. Optional single-step gating via SEQ_SINGLE_STEP_EN.
module microcode_sequencer
  import microcode_pkg::*;
#(
  parameter int unsigned INSTR_W    = 8,
  parameter int unsigned STEP_W     = 3,
  parameter int unsigned FLAG_W     = 2,
  parameter int unsigned CTRL_W     = 16,
  parameter int unsigned IMM_W      = 3,
  parameter int unsigned IMM_LSB    = 3,
  parameter int unsigned FETCH_STEP = 1
) (
  input  logic                             i_clk,
  input  logic                             i_nReset,
  input  logic [FLAG_W-1:0]                i_flags,
  input  logic [INSTR_W-1:0]               i_instruction,
  input  logic                             i_memReady,
  input  logic                             i_resume,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                             i_singleStep,
  input  logic                             i_stepPulse,
`endif
  output logic [FLAG_W+INSTR_W+STEP_W-1:0] o_uAddr,
  input  logic [CTRL_W-1:0]                i_uWord,
  output logic [CTRL_W-3:0]                o_ctrl,
  output logic [2:0]                       o_aluOp,
  output logic [INSTR_W-1:0]               o_immediate,
  output logic                             o_fetch,
  output logic                             o_halt,
  output logic [STEP_W-1:0]                o_step
);

  localparam int unsigned UADDR_W = FLAG_W + INSTR_W + STEP_W;
  localparam logic [STEP_W-1:0] FETCH_S = STEP_W'(FETCH_STEP);

  if (IMM_LSB + IMM_W > INSTR_W) begin : gBadImmField
    $error("immediate field exceeds instruction width");
  end
  if (FETCH_STEP >= (2 ** STEP_W) - 1) begin : gBadFetchStep
    $error("FETCH_STEP must be below the last microstep");
  end
  if (INSTR_W < 3) begin : gBadInstrW
    $error("instruction too narrow for the ALU op field");
  end

  seqState_e           stateQ, stateD;
  logic [INSTR_W-1:0]  r_instr, instrD;
  logic [STEP_W-1:0]   r_step;
  logic                stepClear, stepHold;
  logic                advance;
  logic                eoi;

  assign eoi = i_uWord[UWORD_EOI_BIT];

`ifdef SEQ_SINGLE_STEP_EN
  assign advance = !i_singleStep || i_stepPulse;
`else
  assign advance = 1'b1;
`endif

  seq_step_counter #(
    .STEP_W (STEP_W)
  ) uStepCounter (
    .i_clk    (i_clk),
    .i_nReset (i_nReset),
    .i_clear  (stepClear),
    .i_hold   (stepHold),
    .o_step   (r_step)
  );

  always_comb begin
    stateD    = stateQ;
    instrD    = r_instr;
    stepClear = 1'b0;
    stepHold  = 1'b1;
    if (advance) begin
      unique case (stateQ)
        SEQ_RUN: begin
          if (r_step == FETCH_S) begin
            // Fetch stalls until memory presents valid data.
            if (i_memReady) begin
              instrD   = i_instruction;
              stepHold = 1'b0;
              if (&i_instruction) stateD = SEQ_HALT;
            end
          end else if (r_step > FETCH_S && eoi) begin
            stepClear = 1'b1;
          end else begin
            stepHold = 1'b0;
          end
        end
        SEQ_HALT: begin
          if (i_resume) begin
            stepClear = 1'b1;
            instrD    = '0;
            stateD    = SEQ_RUN;
          end
        end
        default: stateD = SEQ_RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_nReset) begin
      stateQ  <= SEQ_RUN;
      r_instr <= '0;
    end else begin
      stateQ  <= stateD;
      r_instr <= instrD;
    end
  end

  assign o_uAddr     = UADDR_W'(buildUAddr(32'(i_flags), 32'(r_instr), 32'(r_step),
                                           INSTR_W, STEP_W));
  assign o_ctrl      = i_uWord[CTRL_W-1:2];
  assign o_aluOp     = r_instr[2:0];
  assign o_immediate = i_uWord[UWORD_NIMM_BIT] ? '0 : INSTR_W'(r_instr[IMM_LSB +: IMM_W]);
  assign o_fetch     = (r_step == FETCH_S);
  assign o_halt      = (stateQ == SEQ_HALT);
  assign o_step      = r_step;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Scoreboard bench for microcode_sequencer: a driver feeds random and directed
// stimulus into a spec-level model; a monitor compares DUT outputs each cycle.
module tb_microcode_sequencer;

  logic        clk;
  logic        nReset;
  logic [1:0]  flags;
  logic [7:0]  instruction;
  logic        memReady;
  logic        resume;
  logic [12:0] uAddr;
  logic [15:0] uWord;
  logic [13:0] ctrl;
  logic [2:0]  aluOp;
  logic [7:0]  immediate;
  logic        fetch;
  logic        halt;
  logic [2:0]  step;

  microcode_sequencer dut (
    .i_clk         (clk),
    .i_nReset      (nReset),
    .i_flags       (flags),
    .i_instruction (instruction),
    .i_memReady    (memReady),
    .i_resume      (resume),
`ifdef SEQ_SINGLE_STEP_EN
    .i_singleStep  (1'b0),
    .i_stepPulse   (1'b0),
`endif
    .o_uAddr       (uAddr),
    .i_uWord       (uWord),
    .o_ctrl        (ctrl),
    .o_aluOp       (aluOp),
    .o_immediate   (immediate),
    .o_fetch       (fetch),
    .o_halt        (halt),
    .o_step        (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int uAddr;
    int ctrl;
    int aluOp;
    int imm;
    int fetch;
    int halt;
    int step;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: microstep, instruction register, halted flag.
  int   mStep  = 0;
  int   mInstr = 0;
  bit   mHalt  = 0;
  bit   mValid = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cycle(input bit nRst, input int instr, input bit ready, input bit res,
                       input bit eoiBit);
    exp_t e;
    int   f;
    int   uw;
    bit   nImm;
    @(negedge clk);
    f      = int'($urandom_range(0, 3));
    uw     = int'($urandom_range(0, 65535));
    uw[0]  = eoiBit;
    nImm   = uw[1];
    nReset      = nRst;
    flags       = f[1:0];
    instruction = instr[7:0];
    memReady    = ready;
    resume      = res;
    uWord       = uw[15:0];
    if (mValid) begin
      e.uAddr = f * 2048 + mInstr * 8 + mStep;
      e.ctrl  = uw / 4;
      e.aluOp = mInstr % 8;
      e.imm   = nImm ? 0 : (mInstr / 8) % 8;
      e.fetch = (mStep == 1) ? 1 : 0;
      e.halt  = mHalt ? 1 : 0;
      e.step  = mStep;
      expQ.push_back(e);
    end
    // Model state after the coming clock edge.
    if (!nRst) begin
      mStep = 0; mInstr = 0; mHalt = 0; mValid = 1;
    end else if (mValid) begin
      if (mHalt) begin
        if (res) begin
          mStep = 0; mInstr = 0; mHalt = 0;
        end
      end else if (mStep == 1) begin
        if (ready) begin
          mInstr = instr % 256;
          mStep  = 2;
          mHalt  = (mInstr == 255);
        end
      end else if (mStep > 1 && eoiBit) begin
        mStep = 0;
      end else begin
        mStep = (mStep + 1) % 8;
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    #2;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      chk("uAddr", 32'(uAddr), e.uAddr);
      chk("ctrl", 32'(ctrl), e.ctrl);
      chk("aluOp", 32'(aluOp), e.aluOp);
      chk("immediate", 32'(immediate), e.imm);
      chk("fetch", 32'(fetch), e.fetch);
      chk("halt", 32'(halt), e.halt);
      chk("step", 32'(step), e.step);
    end
  end

  task automatic goToFetch();
    for (int i = 0; i < 16 && !(mStep == 1 && !mHalt); i++) cycle(1, 8'h33, 1, 0, 0);
  endtask

  initial begin
    nReset = 0; flags = 0; instruction = 0; memReady = 0; resume = 0; uWord = 0;
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    // Reset mid-instruction at step 5.
    for (int i = 0; i < 5; i++) cycle(1, 8'h11, 1, 0, 0);
    cycle(0, 8'h11, 1, 0, 0);
    cycle(1, 8'h11, 1, 0, 0);
    // Variable-length instruction 0x2A ending at step 3.
    cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(1, 8'h2A, 1, 0, (mStep == 3));
    // Fetch stall: three not-ready cycles, then ready.
    goToFetch();
    for (int i = 0; i < 3; i++) cycle(1, 8'h5C, 0, 0, 1);
    cycle(1, 8'h5C, 1, 0, 0);
    // No EOI at all; EOI at steps 0 and 1 must be ignored.
    for (int i = 0; i < 20; i++) cycle(1, 8'h47, 1, 0, (mStep <= 1));
    // Halt on 0xFF, hold for 10 cycles, resume, then resume pulses in RUN.
    goToFetch();
    cycle(1, 8'hFF, 1, 0, 0);
    for (int i = 0; i < 10; i++) cycle(1, 8'h12, 1, 0, i[0]);
    cycle(1, 8'h12, 1, 1, 0);
    for (int i = 0; i < 12; i++) cycle(1, 8'h21, 1, i[1], (mStep == 4));
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom % 64) != 0,
            (($urandom % 12) == 0) ? 255 : int'($urandom % 255),
            ($urandom % 4) != 0,
            ($urandom % 6) == 0,
            ($urandom % 3) == 0);
    end
    @(negedge clk);
    #3;
    chk("scoreboard drained", 32'(expQ.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
